// File: rtl/llu_pipe_pkg.sv
// llu_pipe_pkg: shared types for the pipelined logic unit.
// Op encoding, FSM states and the op-class helper used by llu_pipe and llu_pipe_logic.
package llu_pipe_pkg;

    typedef enum logic [2:0] {
        LLU_AND = 3'd0,
        LLU_OR  = 3'd1,
        LLU_XOR = 3'd2,
        LLU_NOT = 3'd3,
        LLU_NEG = 3'd4,
        LLU_SHL = 3'd5,
        LLU_SHR = 3'd6,
        LLU_ASR = 3'd7
    } lluOpT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } lluStateT;

    // True for the three shift ops (SHL, SHR, ASR).
    function automatic logic is_shift(input lluOpT op);
        return (op == LLU_SHL) || (op == LLU_SHR) || (op == LLU_ASR);
    endfunction

endpackage

// File: rtl/llu_pipe_logic.sv
// llu_pipe_logic: combinational result for AND/OR/XOR/NOT/NEG.
// With LLU_PIPE_BARREL_EN defined it also contains a log-depth barrel shifter;
// otherwise a shift op returns in1 unchanged (only reached for shamt == 0).
module llu_pipe_logic
    import llu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  lluOpT              op,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] shiftRes;

`ifdef LLU_PIPE_BARREL_EN
    localparam int SHAMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] stage [SHAMT_W+1];
    logic             shiftLeft;
    logic             fillBit;

    assign shiftLeft = (op == LLU_SHL);
    // ASR replicates the sign bit; SHR/SHL fill with zeros.
    assign fillBit   = (op == LLU_ASR) & in1[WIDTH-1];
    assign stage[0]  = in1;

    // Stage gi shifts by 2**gi when shamt bit gi is set.
    genvar gi;
    for (gi = 0; gi < SHAMT_W; gi++) begin : gStage
        localparam int S = 1 << gi;
        assign stage[gi+1] = !in2[gi]  ? stage[gi] :
                             shiftLeft ? {stage[gi][WIDTH-1-S:0], {S{1'b0}}} :
                                         {{S{fillBit}}, stage[gi][WIDTH-1:S]};
    end

    assign shiftRes = stage[SHAMT_W];
`else
    assign shiftRes = in1;
`endif

    // Single-cycle result selection; NEG wraps modulo 2**WIDTH.
    always_comb begin
        result = '0;
        case (op)
            LLU_AND: result = in1 & in2;
            LLU_OR:  result = in1 | in2;
            LLU_XOR: result = in1 ^ in2;
            LLU_NOT: result = ~in1;
            LLU_NEG: result = (~in1) + WIDTH'(1);
            default: result = shiftRes;
        endcase
    end

endmodule

// File: rtl/llu_pipe.sv
// llu_pipe: handshaked logic/shift unit with registered result and zero/neg flags.
// FSM IDLE -> (SHIFT) -> DONE. Shifts run one bit per cycle unless
// LLU_PIPE_BARREL_EN is defined, in which case every op completes in one cycle.
module llu_pipe
    import llu_pipe_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               out_neg,
    output logic               busy
);

    lluStateT         stateReg, stateNext;
    lluOpT            opIn;
    logic             accept;
    logic             startIter;
    logic [WIDTH-1:0] logicRes;
    logic             loadOut;
    logic [WIDTH-1:0] loadVal;
    logic [WIDTH-1:0] dataReg;
    logic             zeroReg, negReg;

    assign opIn = lluOpT'(op);

    llu_pipe_logic #(.WIDTH(WIDTH)) uLogic (
        .op     (opIn),
        .in1    (in1),
        .in2    (in2),
        .result (logicRes)
    );

    assign in_ready  = !rst && ((stateReg == ST_IDLE) ||
                                ((stateReg == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (stateReg == ST_DONE);
    assign out_data  = dataReg;
    assign out_zero  = zeroReg;
    assign out_neg   = negReg;

`ifdef LLU_PIPE_BARREL_EN
    assign startIter = 1'b0;
    assign busy      = 1'b0;
`else
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] cntReg;
    logic [WIDTH-1:0]   workReg;
    lluOpT              shiftOpReg;
    logic [WIDTH-1:0]   shiftStep;

    assign shamt     = in2[SHAMT_W-1:0];
    assign startIter = accept && is_shift(opIn) && (shamt != '0);
    assign busy      = (stateReg == ST_SHIFT);

    // One-bit shift of the work register in the captured direction.
    always_comb begin
        shiftStep = {1'b0, workReg[WIDTH-1:1]};
        case (shiftOpReg)
            LLU_SHL: shiftStep = {workReg[WIDTH-2:0], 1'b0};
            LLU_ASR: shiftStep = {workReg[WIDTH-1], workReg[WIDTH-1:1]};
            default: shiftStep = {1'b0, workReg[WIDTH-1:1]};
        endcase
    end

    // Work register and remaining-shift counter for the iterative shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            workReg    <= '0;
            cntReg     <= '0;
            shiftOpReg <= LLU_SHL;
        end else if (startIter) begin
            workReg    <= in1;
            cntReg     <= shamt;
            shiftOpReg <= opIn;
        end else if (stateReg == ST_SHIFT) begin
            workReg    <= shiftStep;
            cntReg     <= cntReg - SHAMT_W'(1);
        end
    end
`endif

    // Pick which value, if any, is captured into the output registers this cycle.
    always_comb begin
        loadOut = 1'b0;
        loadVal = logicRes;
        if (accept && !startIter) begin
            loadOut = 1'b1;
        end
`ifndef LLU_PIPE_BARREL_EN
        else if ((stateReg == ST_SHIFT) && (cntReg == SHAMT_W'(1))) begin
            loadOut = 1'b1;
            loadVal = shiftStep;
        end
`endif
    end

    // Result and flags are captured together and held until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataReg <= '0;
            zeroReg <= 1'b0;
            negReg  <= 1'b0;
        end else if (loadOut) begin
            dataReg <= loadVal;
            zeroReg <= (loadVal == '0);
            negReg  <= loadVal[WIDTH-1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next state: acceptance from IDLE or DONE jumps straight to the new op's state.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE, ST_DONE: begin
                if ((stateReg == ST_DONE) && out_ready) begin
                    stateNext = ST_IDLE;
                end
                if (accept) begin
                    stateNext = startIter ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
`ifndef LLU_PIPE_BARREL_EN
                if (cntReg == SHAMT_W'(1)) begin
                    stateNext = ST_DONE;
                end
`else
                stateNext = ST_IDLE;
`endif
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_llu_pipe.sv
// tb_llu_pipe: directed self-checking bench for llu_pipe (either build of LLU_PIPE_BARREL_EN).
module tb_llu_pipe;
    import llu_pipe_pkg::*;

`ifdef LLU_PIPE_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic        out_neg;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    llu_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issue one op with out_ready high; report result and latency (-1 on timeout).
    // stallOk is cleared if busy/in_ready are wrong in any cycle spent waiting.
    task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] d, output logic z, output logic n,
                         output int lat, output logic stallOk);
        int guard;
        op = o; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat = 0;
        stallOk = 1'b1;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            in1 = ~a;                 // post-acceptance changes must be ignored
            in2 = 16'h5555;
            lat++;
            if (!out_valid && !(busy === 1'b1 && in_ready === 1'b0)) stallOk = 1'b0;
        end while (!out_valid && lat < 40);
        if (!out_valid) lat = -1;
        d = out_data; z = out_zero; n = out_neg;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; in1 = '0; in2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_zero, out_neg, busy, in_ready} !== 21'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {out_valid, out_data, out_zero, out_neg, busy, in_ready}, 21'h0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        $display("reset: done");
    endtask

    task automatic test_logic_ops();
        logic [2:0]  tOp [8] = '{LLU_AND, LLU_XOR, LLU_NEG, LLU_NEG, LLU_NEG, LLU_NOT, LLU_OR, LLU_AND};
        logic [15:0] tA  [8] = '{16'hF0F0, 16'h1234, 16'h0001, 16'h0000, 16'h8000, 16'h00FF, 16'hA5A5, 16'hFFFF};
        logic [15:0] tB  [8] = '{16'h3C3C, 16'h1234, 16'hBEEF, 16'h0000, 16'h1111, 16'h0000, 16'h5A00, 16'h8001};
        logic [15:0] tE  [8] = '{16'h3030, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000, 16'hFF00, 16'hFFA5, 16'h8001};
        logic [1:0]  tF  [8] = '{2'b00,    2'b10,    2'b01,    2'b10,    2'b01,    2'b01,    2'b01,    2'b01};
        logic [15:0] d;
        logic        z, n, ok;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            do_op(tOp[i], tA[i], tB[i], d, z, n, lat, ok);
            $display("logic op=%0d a=%h b=%h -> %h z=%b n=%b lat=%0d", tOp[i], tA[i], tB[i], d, z, n, lat);
            checks++;
            if (d !== tE[i]) begin
                errors++;
                $display("FAIL logic_data[%0d]: got %h expected %h", i, d, tE[i]);
            end
            checks++;
            if ({z, n} !== tF[i]) begin
                errors++;
                $display("FAIL logic_flags[%0d]: got zn=%b expected %b", i, {z, n}, tF[i]);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL logic_latency[%0d]: got %0d expected 1", i, lat);
            end
        end
    endtask

    task automatic test_shifts();
        logic [2:0]  tOp [6] = '{LLU_SHL, LLU_ASR, LLU_SHR, LLU_SHR, LLU_ASR, LLU_SHL};
        logic [15:0] tA  [6] = '{16'h0001, 16'h8000, 16'h8000, 16'h00F0, 16'h8001, 16'h0003};
        logic [15:0] tB  [6] = '{16'h000F, 16'h0004, 16'h0004, 16'h0013, 16'h0010, 16'h0002};
        logic [15:0] tE  [6] = '{16'h8000, 16'hF800, 16'h0800, 16'h001E, 16'h8001, 16'h000C};
        logic [1:0]  tF  [6] = '{2'b01,    2'b01,    2'b00,    2'b00,    2'b01,    2'b00};
        int          tSh [6] = '{15, 4, 4, 3, 0, 2};
        logic [15:0] d;
        logic        z, n, ok;
        int          lat, expLat;
        for (int i = 0; i < 6; i++) begin
            do_op(tOp[i], tA[i], tB[i], d, z, n, lat, ok);
            expLat = BARREL ? 1 : 1 + tSh[i];
            $display("shift op=%0d a=%h b=%h -> %h z=%b n=%b lat=%0d", tOp[i], tA[i], tB[i], d, z, n, lat);
            checks++;
            if (d !== tE[i]) begin
                errors++;
                $display("FAIL shift_data[%0d]: got %h expected %h", i, d, tE[i]);
            end
            checks++;
            if ({z, n} !== tF[i]) begin
                errors++;
                $display("FAIL shift_flags[%0d]: got zn=%b expected %b", i, {z, n}, tF[i]);
            end
            checks++;
            if (lat !== expLat) begin
                errors++;
                $display("FAIL shift_latency[%0d]: got %0d expected %0d", i, lat, expLat);
            end
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL shift_busy_ready[%0d]: got stall_ok=%b expected 1", i, ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic        z, n, ok;
        int          lat, start;
        @(negedge clk);
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            do_op(LLU_XOR, 16'(i), 16'h00FF, d, z, n, lat, ok);
            $display("b2b xor %h ^ 00ff -> %h", 16'(i), d);
            checks++;
            if (d !== (16'h00FF ^ 16'(i))) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", i, d, 16'h00FF ^ 16'(i));
            end
        end
        checks++;
        if (cyc - start !== 4) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d cycles expected 4", cyc - start);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        op = LLU_AND; in1 = 16'hFF00; in2 = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in1 = 16'h1234;
            checks++;
            if ({out_valid, in_ready, out_data} !== {2'b10, 16'h0F00}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h expected v=1 r=0 d=0f00",
                         i, out_valid, in_ready, out_data);
            end
        end
        out_ready = 1'b1; in_valid = 1'b1; op = LLU_AND; in1 = 16'h00FF; in2 = 16'h0F0F;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        $display("backpressure: queued and -> v=%b d=%h", out_valid, out_data);
        checks++;
        if ({out_valid, out_data, out_zero, out_neg} !== {1'b1, 16'h000F, 2'b00}) begin
            errors++;
            $display("FAIL bp_next_result: got v=%b d=%h z=%b n=%b expected v=1 d=000f z=0 n=0",
                     out_valid, out_data, out_zero, out_neg);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] d;
        logic        z, n, ok, sawValid;
        int          lat;
        @(negedge clk);
        op = LLU_SHL; in1 = 16'h0001; in2 = 16'h000A; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== !BARREL) begin
            errors++;
            $display("FAIL midrst_busy: got %b expected %b", busy, !BARREL);
        end
        rst = 1'b1;
        #1;
        $display("mid reset asserted: v=%b d=%h busy=%b", out_valid, out_data, busy);
        checks++;
        if ({out_valid, out_data, out_zero, out_neg, busy, in_ready} !== 21'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected %h",
                     {out_valid, out_data, out_zero, out_neg, busy, in_ready}, 21'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale_valid: got out_valid seen=1 expected 0");
        end
        do_op(LLU_OR, 16'h00F0, 16'h0F00, d, z, n, lat, ok);
        $display("post-reset or 00f0|0f00 -> %h lat=%0d", d, lat);
        checks++;
        if ({d, z, n} !== {16'h0FF0, 2'b00} || lat !== 1) begin
            errors++;
            $display("FAIL midrst_or: got d=%h z=%b n=%b lat=%0d expected 0ff0 0 0 1", d, z, n, lat);
        end
    endtask

    initial begin
        test_reset();
        test_logic_ops();
        test_shifts();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
